spi_test_ctrl: RTL and testbench



---
 rtl/spi_test_pkg.sv | 28 ++
 rtl/spi_test_ctrl_if.sv | 27 ++
 rtl/spi_in_sync.sv | 50 +++++
 rtl/spi_test_ctrl.sv | 146 ++++++++++++++
 tb/tb_spi_test_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/spi_test_pkg.sv
`timescale 1ns/1ps
// Shared widths, command codes and FSM state encoding for the SPI test controller.
// No logic; consumed by the controller, its synchronizer and its interface.
package spi_test_pkg;

    localparam int CMD_W      = 32;
    localparam int DATA_W     = 32;
    localparam int FRAME_BITS = 64;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    localparam logic [CMD_W-1:0] CMD_NOP   = 32'h0000_0000;
    localparam logic [CMD_W-1:0] CMD_CFG   = 32'h0000_0001;
    localparam logic [CMD_W-1:0] CMD_STOP  = 32'h0000_0002;
    localparam logic [CMD_W-1:0] CMD_START = 32'h0000_0003;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_EXEC,
        ST_DONE
    } state_t;

    function automatic logic cmd_is_legal(input logic [CMD_W-1:0] cmd);
        return cmd <= CMD_START;
    endfunction

endpackage

// File: rtl/spi_test_ctrl_if.sv
`timescale 1ns/1ps
// SPI pins plus the control/status outputs of the SPI test controller.
// slave = controller side, master = the agent driving the SPI bus and observing status.
interface spi_test_ctrl_if;
    import spi_test_pkg::*;

    logic              scs_i;
    logic              sck_i;
    logic              sdi_i;
    logic              sdo_o;
    logic [DATA_W-1:0] cfg_o;
    logic              cfg_valid_o;
    logic [31:0]       timer_o;
    logic              timer_run_o;
    logic              frame_err_o;

    modport slave (
        input  scs_i, sck_i, sdi_i,
        output sdo_o, cfg_o, cfg_valid_o, timer_o, timer_run_o, frame_err_o
    );

    modport master (
        output scs_i, sck_i, sdi_i,
        input  sdo_o, cfg_o, cfg_valid_o, timer_o, timer_run_o, frame_err_o
    );

endinterface

// File: rtl/spi_in_sync.sv
`timescale 1ns/1ps
// Synchronizes scs/sck/sdi into clk and derives one-clk edge pulses; latency STAGES clks.
// No backpressure. Edge pulses are masked until the chains have flushed their reset values.
module spi_in_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scs,
    input  logic sck,
    input  logic sdi,
    output logic scs_s,
    output logic sdi_s,
    output logic sck_rise,
    output logic sck_fall,
    output logic scs_fall,
    output logic scs_rise
);

    // One extra flop on scs/sck holds the previous synchronized value for edge detection.
    logic [STAGES:0]   scs_q;
    logic [STAGES:0]   sck_q;
    logic [STAGES-1:0] sdi_q;
    logic [STAGES:0]   settle_q;
    logic              ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            scs_q    <= '1;
            sck_q    <= '0;
            sdi_q    <= '0;
            settle_q <= '0;
        end else begin
            scs_q    <= (STAGES+1)'({scs_q, scs});
            sck_q    <= (STAGES+1)'({sck_q, sck});
            sdi_q    <= STAGES'({sdi_q, sdi});
            settle_q <= (STAGES+1)'({settle_q, 1'b1});
        end
    end

    // A line held low across reset release must not look like a fresh edge.
    assign ready    = settle_q[STAGES];
    assign scs_s    = scs_q[STAGES-1];
    assign sdi_s    = sdi_q[STAGES-1];
    assign sck_rise = ready &  sck_q[STAGES-1] & ~sck_q[STAGES];
    assign sck_fall = ready & ~sck_q[STAGES-1] &  sck_q[STAGES];
    assign scs_fall = ready & ~scs_q[STAGES-1] &  scs_q[STAGES];
    assign scs_rise = ready &  scs_q[STAGES-1] & ~scs_q[STAGES];

endmodule

// File: rtl/spi_test_ctrl.sv
`timescale 1ns/1ps
// SPI mode-0 slave decoding 32-bit cmd + 32-bit data frames into cfg/timer control.
// Effects land one clk after the EXEC cycle; no backpressure, sdo returns the timer snapshot.
module spi_test_ctrl
    import spi_test_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SAT_TIMER   = 1
) (
    input  logic            clk,
    input  logic            rst,
    spi_test_ctrl_if.slave  bus
);

    logic scs_s, sdi_s, sck_rise, sck_fall, scs_fall, scs_rise;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [DATA_W-1:0]  rx_sr_q;
    logic [DATA_W-1:0]  tx_sr_q;
    logic [CMD_W-1:0]   cmd_q;
    logic [DATA_W-1:0]  cfg_q;
    logic [31:0]        timer_q;
    logic               cfg_vld_q, run_q, err_q;

    logic sample, do_cfg, do_stop, do_start, err_set, sdo;

    spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .scs      (bus.scs_i),
        .sck      (bus.sck_i),
        .sdi      (bus.sdi_i),
        .scs_s    (scs_s),
        .sdi_s    (sdi_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .scs_fall (scs_fall),
        .scs_rise (scs_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (scs_fall) state_d = ST_CMD;
            ST_CMD: begin
                if (scs_rise) state_d = ST_IDLE;
                else if (sck_rise && bit_cnt_q == CNT_W'(CMD_W - 1)) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (scs_rise) state_d = ST_IDLE;
                else if (sck_rise && bit_cnt_q == CNT_W'(FRAME_BITS - 1)) state_d = ST_EXEC;
            end
            ST_EXEC: state_d = ST_DONE;
            // Level test so a deselect that lands during EXEC is not lost.
            ST_DONE: if (scs_s) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sample   = 1'b0;
        do_cfg   = 1'b0;
        do_stop  = 1'b0;
        do_start = 1'b0;
        err_set  = 1'b0;
        sdo      = 1'b0;
        case (state_q)
            ST_CMD: begin
                sample  = sck_rise;
                err_set = scs_rise;
            end
            ST_DATA: begin
                sample  = sck_rise;
                err_set = scs_rise;
                sdo     = tx_sr_q[DATA_W-1];
            end
            ST_EXEC: begin
                do_cfg   = (cmd_q == CMD_CFG);
                do_stop  = (cmd_q == CMD_STOP);
                do_start = (cmd_q == CMD_START);
                err_set  = !cmd_is_legal(cmd_q);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= '0;
            rx_sr_q   <= '0;
            tx_sr_q   <= '0;
            cmd_q     <= '0;
        end else begin
            if (state_q == ST_IDLE && scs_fall) begin
                bit_cnt_q <= '0;
            end
            if (sample) begin
                rx_sr_q   <= {rx_sr_q[DATA_W-2:0], sdi_s};
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            // The fall right after the 32nd rise must keep bit 31 on the line for the 33rd rise.
            if (state_q == ST_CMD && state_d == ST_DATA) begin
                cmd_q   <= {rx_sr_q[CMD_W-2:0], sdi_s};
                tx_sr_q <= timer_q;
            end else if (state_q == ST_DATA && sck_fall && bit_cnt_q != CNT_W'(CMD_W)) begin
                tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q     <= '0;
            cfg_vld_q <= 1'b0;
            err_q     <= 1'b0;
            timer_q   <= '0;
            run_q     <= 1'b0;
        end else begin
            cfg_vld_q <= do_cfg;
            err_q     <= err_set;
            if (do_cfg) cfg_q <= rx_sr_q;
            if (do_start) begin
                timer_q <= '0;
                run_q   <= 1'b1;
            end else if (do_stop) begin
                run_q   <= 1'b0;
            end else if (run_q && (SAT_TIMER == 0 || !(&timer_q))) begin
                timer_q <= timer_q + 32'd1;
            end
        end
    end

    assign bus.sdo_o       = sdo;
    assign bus.cfg_o       = cfg_q;
    assign bus.cfg_valid_o = cfg_vld_q;
    assign bus.timer_o     = timer_q;
    assign bus.timer_run_o = run_q;
    assign bus.frame_err_o = err_q;

endmodule

// File: tb/tb_spi_test_ctrl.sv
`timescale 1ns/1ps
// Bench for spi_test_ctrl: bit-banged SPI frames, scoreboard queues for cfg writes and sdo readback.
module tb_spi_test_ctrl;
    import spi_test_pkg::*;

    localparam time SCK_HALF = 100ns;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_test_ctrl_if bus ();

    spi_test_ctrl #(.SYNC_STAGES(2), .SAT_TIMER(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int cfg_pulses = 0;
    int err_pulses = 0;
    int run_rise_cyc = -1;
    int run_fall_cyc = -1;
    logic run_prev = 1'b0;

    logic [31:0] exp_cfg_q[$];
    logic [31:0] exp_sdo_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cfg_valid_o) begin
                cfg_pulses++;
                if (exp_cfg_q.size() == 0) chk("cfg_unexpected", 1, 0);
                else                       chk("cfg_value", bus.cfg_o, exp_cfg_q.pop_front());
            end
            if (bus.frame_err_o) err_pulses++;
            if (bus.timer_run_o && !run_prev) run_rise_cyc = cyc;
            if (!bus.timer_run_o && run_prev) run_fall_cyc = cyc;
        end
        run_prev = bus.timer_run_o;
    end

    // stop_at < 64 deselects early; rst_at >= 0 pulses rst before that bit's rising edge.
    task automatic send_frame(input logic [31:0] cmd, input logic [31:0] data,
                              input int stop_at, input int rst_at, output logic [31:0] rx);
        logic [63:0] f;
        f  = {cmd, data};
        rx = '0;
        bus.scs_i = 1'b0;
        #SCK_HALF;
        for (int i = 0; i < FRAME_BITS; i++) begin
            if (i == stop_at) break;
            bus.sdi_i = f[63-i];
            if (i == rst_at) begin
                @(posedge clk); #1 rst = 1'b1;
                repeat (4) @(posedge clk);
                #1 rst = 1'b0;
            end
            #SCK_HALF;
            if (i >= CMD_W) rx = {rx[30:0], bus.sdo_o};
            bus.sck_i = 1'b1;
            #SCK_HALF;
            bus.sck_i = 1'b0;
        end
        #SCK_HALF;
        bus.scs_i = 1'b1;
        bus.sdi_i = 1'b0;
        #(4 * SCK_HALF);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rx;
        logic [31:0] exp_v;
        int c0, e0;

        bus.scs_i = 1'b1;
        bus.sck_i = 1'b0;
        bus.sdi_i = 1'b0;
        #300us;
        @(negedge clk);
        chk("rst_sdo",       bus.sdo_o,       0);
        chk("rst_cfg",       bus.cfg_o,       0);
        chk("rst_cfg_valid", bus.cfg_valid_o, 0);
        chk("rst_timer",     bus.timer_o,     0);
        chk("rst_run",       bus.timer_run_o, 0);
        chk("rst_err",       bus.frame_err_o, 0);
        @(posedge clk); #1 rst = 1'b0;
        #(4 * SCK_HALF);

        // configuration write
        c0 = cfg_pulses; e0 = err_pulses;
        exp_cfg_q.push_back(32'h0010_0267);
        send_frame(CMD_CFG, 32'h0010_0267, 64, -1, rx);
        chk("cfg_write",     bus.cfg_o, 32'h0010_0267);
        chk("cfg_pulse_cnt", cfg_pulses - c0, 1);
        chk("cfg_no_err",    err_pulses - e0, 0);

        // start, wait, stop: timer equals clks strictly between the two EXEC cycles
        send_frame(CMD_START, 32'h0, 64, -1, rx);
        chk("start_run", bus.timer_run_o, 1);
        #100us;
        send_frame(CMD_STOP, 32'h0, 64, -1, rx);
        chk("stop_run", bus.timer_run_o, 0);
        exp_v = 32'(run_fall_cyc - run_rise_cyc - 1);
        chk("stop_timer", bus.timer_o, exp_v);
        repeat (50) @(negedge clk);
        chk("stop_timer_hold", bus.timer_o, exp_v);

        // NOP returns the stopped timer on sdo
        e0 = err_pulses;
        exp_sdo_q.push_back(exp_v);
        send_frame(CMD_NOP, 32'hCAFE_F00D, 64, -1, rx);
        chk("nop_sdo",   rx, exp_sdo_q.pop_front());
        chk("nop_timer", bus.timer_o, exp_v);
        chk("nop_cfg",   bus.cfg_o, 32'h0010_0267);
        chk("nop_no_err", err_pulses - e0, 0);

        // deselect after 20 bits aborts the frame
        c0 = cfg_pulses; e0 = err_pulses;
        send_frame(CMD_CFG, 32'hDEAD_BEEF, 20, -1, rx);
        chk("abort_err_cnt", err_pulses - e0, 1);
        chk("abort_cfg",     bus.cfg_o, 32'h0010_0267);
        chk("abort_timer",   bus.timer_o, exp_v);
        chk("abort_no_cfg",  cfg_pulses - c0, 0);
        exp_cfg_q.push_back(32'hA5A5_0F0F);
        send_frame(CMD_CFG, 32'hA5A5_0F0F, 64, -1, rx);
        chk("after_abort_cfg", bus.cfg_o, 32'hA5A5_0F0F);

        // illegal command
        c0 = cfg_pulses; e0 = err_pulses;
        send_frame(32'h0000_0005, 32'h1111_2222, 64, -1, rx);
        chk("bad_err_cnt", err_pulses - e0, 1);
        chk("bad_cfg",     bus.cfg_o, 32'hA5A5_0F0F);
        chk("bad_timer",   bus.timer_o, exp_v);
        chk("bad_run",     bus.timer_run_o, 0);
        chk("bad_no_cfg",  cfg_pulses - c0, 0);

        // reset in the middle of the data phase
        c0 = cfg_pulses; e0 = err_pulses;
        send_frame(CMD_CFG, 32'h1234_5678, 64, 40, rx);
        chk("midrst_cfg",    bus.cfg_o, 0);
        chk("midrst_timer",  bus.timer_o, 0);
        chk("midrst_run",    bus.timer_run_o, 0);
        chk("midrst_sdo",    bus.sdo_o, 0);
        chk("midrst_no_err", err_pulses - e0, 0);
        chk("midrst_no_cfg", cfg_pulses - c0, 0);
        exp_cfg_q.push_back(32'h1234_5678);
        send_frame(CMD_CFG, 32'h1234_5678, 64, -1, rx);
        chk("after_rst_cfg", bus.cfg_o, 32'h1234_5678);

        // saturation at the top of the range
        send_frame(CMD_START, 32'h0, 64, -1, rx);
        @(negedge clk);
        force dut.timer_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.timer_q;
        repeat (20) @(negedge clk);
        chk("sat_timer",      bus.timer_o, 32'hFFFF_FFFF);
        chk("sat_run",        bus.timer_run_o, 1);
        repeat (10) @(negedge clk);
        chk("sat_timer_hold", bus.timer_o, 32'hFFFF_FFFF);

        chk("cfg_queue_drained", exp_cfg_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
